// File: rtl/min_pkg.sv
// MIN framing constants and the transmitter state encoding.
// Latency: none; this file holds definitions only.
// Backpressure: none.
package min_pkg;

    localparam logic [7:0]  SOF_BYTE       = 8'hAA;
    localparam logic [7:0]  EOF_BYTE       = 8'h55;
    localparam logic [7:0]  STUFF_BYTE     = 8'h55;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB8_8320;
    localparam logic [7:0]  TRANSPORT_FLAG = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_HDR,
        ST_PAYLOAD,
        ST_CRC,
        ST_STUFF,
        ST_EOF
    } tx_state_e;

endpackage

// File: rtl/min_frame_tx_if.sv
// Byte stream leaving the MIN transmitter towards the UART.
// Latency: none; wiring only.
// Backpressure: a byte moves when o_valid and i_ready are both high.
interface min_frame_tx_if;

    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data;

    modport master (output o_valid, output o_data, input i_ready);
    modport slave  (input o_valid, input o_data, output i_ready);

endinterface

// File: rtl/min_crc32_byte.sv
// One byte step of the reflected CRC-32 (poly 0xEDB88320).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit state_out.
module min_crc32_byte
    import min_pkg::*;
(
    input  logic [31:0] state_in,
    input  logic [7:0]  data_in,
    output logic [31:0] state_out
);

    logic [31:0] c;

    // Fold the byte in, then eight LSB-first shift/xor steps.
    always_comb begin
        c = state_in ^ {24'd0, data_in};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        state_out = c;
    end

endmodule

// File: rtl/min_frame_tx.sv
// MIN frame transmitter: SOF, header, payload, CRC32, EOF with 0xAA 0xAA -> 0x55 stuffing.
// Latency: first SOF byte is presented the cycle after i_start is accepted.
// Backpressure: o_data/state/CRC hold while o_valid && !i_ready. Optional macro: MIN_TX_TRANSPORT_EN.
module min_frame_tx
    import min_pkg::*;
#(
    parameter int MAX_PAYLOAD = 16,
    parameter int LEN_WIDTH   = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [7:0]               i_id,
    input  logic [LEN_WIDTH-1:0]     i_len,
    input  logic [MAX_PAYLOAD*8-1:0] i_data,
    output logic                     o_busy,
    output logic                     o_len_err,
    output logic                     o_done,
    min_frame_tx_if.master           tx
);

    localparam int PTOP = MAX_PAYLOAD * 8 - 1;

`ifdef MIN_TX_TRANSPORT_EN
    localparam logic [7:0] HDR_LAST = 8'd2;
`else
    localparam logic [7:0] HDR_LAST = 8'd1;
`endif

    tx_state_e               state_q, state_d;
    tx_state_e               ret_q, ret_d;
    tx_state_e               nxt_state;
    logic [7:0]              idx_q, idx_d, nxt_idx;
    logic [5:0]              id_q, id_d;
    logic [7:0]              len_q, len_d;
    logic [MAX_PAYLOAD*8-1:0] pay_q, pay_d;
    logic [31:0]             crc_q, crc_d, crc_upd;
    logic [1:0]              cnt_q, cnt_d, run;
    logic [7:0]              data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    len_err_q, len_err_d;
    logic                    xfer;
`ifdef MIN_TX_TRANSPORT_EN
    logic [7:0]              seq_q, seq_d;
`endif

    // Only the low six id bits belong in the frame.
    logic unused_id_bits;
    assign unused_id_bits = ^i_id[7:6];

    // CRC advances over the byte currently held in data_q.
    min_crc32_byte u_crc (
        .state_in  (crc_q),
        .data_in   (data_q),
        .state_out (crc_upd)
    );

    // Byte that belongs at a field position; the payload register is shifted
    // so the current payload byte is always in its top byte.
    function automatic logic [7:0] field_byte(input tx_state_e st, input logic [7:0] idx,
                                              input logic [31:0] crc, input logic [7:0] pay_top);
        logic [7:0]  b;
        logic [31:0] fcs;
        b   = 8'h00;
        fcs = ~crc;
        case (st)
            ST_HDR: begin
`ifdef MIN_TX_TRANSPORT_EN
                if (idx == 8'd0)      b = {2'b00, id_q} | TRANSPORT_FLAG;
                else if (idx == 8'd1) b = seq_q;
                else                  b = len_q;
`else
                b = (idx == 8'd0) ? {2'b00, id_q} : len_q;
`endif
            end
            ST_PAYLOAD: b = pay_top;
            ST_CRC: begin
                case (idx[1:0])
                    2'd0:    b = fcs[31:24];
                    2'd1:    b = fcs[23:16];
                    2'd2:    b = fcs[15:8];
                    default: b = fcs[7:0];
                endcase
            end
            ST_EOF:  b = EOF_BYTE;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign xfer = valid_q & tx.i_ready;

    // Next-state and next-byte selection; everything holds unless a byte moves.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        idx_d     = idx_q;
        id_d      = id_q;
        len_d     = len_q;
        pay_d     = pay_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        len_err_d = 1'b0;
        nxt_state = state_q;
        nxt_idx   = idx_q;
        run       = cnt_q;
`ifdef MIN_TX_TRANSPORT_EN
        seq_d     = seq_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SOF;
                    idx_d   = 8'd0;
                    id_d    = i_id[5:0];
                    pay_d   = i_data;
                    crc_d   = CRC_INIT;
                    cnt_d   = 2'd0;
                    data_d  = SOF_BYTE;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    if (int'(i_len) > MAX_PAYLOAD) begin
                        len_d     = 8'(MAX_PAYLOAD);
                        len_err_d = 1'b1;
                    end else begin
                        len_d = 8'(i_len);
                    end
                end
            end
            ST_SOF: begin
                if (xfer) begin
                    if (idx_q == 8'd2) begin
                        state_d = ST_HDR;
                        idx_d   = 8'd0;
                        cnt_d   = 2'd0;
                        data_d  = field_byte(ST_HDR, 8'd0, crc_q, pay_q[PTOP -: 8]);
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            ST_HDR, ST_PAYLOAD, ST_CRC: begin
                if (xfer) begin
                    if (state_q != ST_CRC) crc_d = crc_upd;
                    if (state_q == ST_PAYLOAD) pay_d = pay_q << 8;
                    nxt_state = state_q;
                    nxt_idx   = idx_q + 8'd1;
                    case (state_q)
                        ST_HDR: begin
                            if (idx_q == HDR_LAST) begin
                                nxt_idx   = 8'd0;
                                nxt_state = (len_q == 8'd0) ? ST_CRC : ST_PAYLOAD;
                            end
                        end
                        ST_PAYLOAD: begin
                            if (idx_q == len_q - 8'd1) begin
                                nxt_idx   = 8'd0;
                                nxt_state = ST_CRC;
                            end
                        end
                        default: begin
                            if (idx_q == 8'd3) begin
                                nxt_idx   = 8'd0;
                                nxt_state = ST_EOF;
                            end
                        end
                    endcase
                    run   = (data_q == SOF_BYTE) ? cnt_q + 2'd1 : 2'd0;
                    idx_d = nxt_idx;
                    if (run == 2'd2) begin
                        // Two 0xAA in a row inside the frame body: break the run.
                        state_d = ST_STUFF;
                        ret_d   = nxt_state;
                        cnt_d   = 2'd0;
                        data_d  = STUFF_BYTE;
                    end else begin
                        state_d = nxt_state;
                        cnt_d   = run;
                        data_d  = field_byte(nxt_state, nxt_idx, crc_d, pay_d[PTOP -: 8]);
                    end
                end
            end
            ST_STUFF: begin
                if (xfer) begin
                    state_d = ret_q;
                    data_d  = field_byte(ret_q, idx_q, crc_q, pay_q[PTOP -: 8]);
                end
            end
            ST_EOF: begin
                if (xfer) begin
                    state_d = ST_IDLE;
                    idx_d   = 8'd0;
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef MIN_TX_TRANSPORT_EN
                    seq_d   = seq_q + 8'd1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; synchronous reset abandons any frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            idx_q     <= 8'd0;
            id_q      <= 6'd0;
            len_q     <= 8'd0;
            pay_q     <= '0;
            crc_q     <= CRC_INIT;
            cnt_q     <= 2'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
`ifdef MIN_TX_TRANSPORT_EN
            seq_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            idx_q     <= idx_d;
            id_q      <= id_d;
            len_q     <= len_d;
            pay_q     <= pay_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
`ifdef MIN_TX_TRANSPORT_EN
            seq_q     <= seq_d;
`endif
        end
    end

    assign o_busy     = busy_q;
    assign o_len_err  = len_err_q;
    assign o_done     = done_q;
    assign tx.o_valid = valid_q;
    assign tx.o_data  = data_q;

endmodule

// File: tb/tb_min_frame_tx.sv
// Directed bench for min_frame_tx: frame bytes, stuffing, CRC, backpressure, reset.
// Latency: checks SOF presented one cycle after accept and o_done one cycle after EOF.
// Backpressure: drives i_ready high or randomly and checks o_data holds while stalled.
module tb_min_frame_tx;

    localparam int MAXP = 16;
    localparam int LENW = $clog2(MAXP + 1);

`ifdef MIN_TX_TRANSPORT_EN
    localparam int T1_N = 13;
`else
    localparam int T1_N = 12;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic [7:0]        i_id;
    logic [LENW-1:0]   i_len;
    logic [MAXP*8-1:0] i_data;
    logic              o_busy, o_len_err, o_done;

    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] seq_m = 8'd0;

    min_frame_tx_if tx_if ();

    min_frame_tx #(.MAX_PAYLOAD(MAXP)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_id      (i_id),
        .i_len     (i_len),
        .i_data    (i_data),
        .o_busy    (o_busy),
        .o_len_err (o_len_err),
        .o_done    (o_done),
        .tx        (tx_if)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference frame: header, payload, bit-serial CRC-32, then stuffing and framing.
    task automatic build_exp(input logic [7:0] id, input int len, input logic [MAXP*8-1:0] pay,
                             input logic [7:0] seq);
        logic [7:0]  body[$];
        logic [31:0] c;
        logic        fb;
        int          n, run;
        n = (len > MAXP) ? MAXP : len;
        body.delete();
`ifdef MIN_TX_TRANSPORT_EN
        body.push_back((id & 8'h3F) | 8'h80);
        body.push_back(seq);
`else
        body.push_back(id & 8'h3F);
        if (seq != seq) body.push_back(8'h00);
`endif
        body.push_back(8'(n));
        for (int k = 0; k < n; k++) body.push_back(pay[(MAXP - k) * 8 - 1 -: 8]);
        c = 32'hFFFF_FFFF;
        foreach (body[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ body[i][b];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
            end
        end
        c = ~c;
        body.push_back(c[31:24]);
        body.push_back(c[23:16]);
        body.push_back(c[15:8]);
        body.push_back(c[7:0]);
        exp_q.delete();
        repeat (3) exp_q.push_back(8'hAA);
        run = 0;
        foreach (body[i]) begin
            exp_q.push_back(body[i]);
            run = (body[i] == 8'hAA) ? run + 1 : 0;
            if (run == 2) begin
                exp_q.push_back(8'h55);
                run = 0;
            end
        end
        exp_q.push_back(8'h55);
    endtask

    // Start a frame at a negedge and collect every transferred byte until o_done.
    task automatic run_frame(input string name, input logic [7:0] id, input int len,
                             input logic [MAXP*8-1:0] pay, input bit rnd);
        int         cyc, lerr;
        bit         done_seen, stall, xfer_prev;
        logic [7:0] held;
        build_exp(id, len, pay, seq_m);
        got_q.delete();
        i_start = 1'b1;
        i_id    = id;
        i_len   = len[LENW-1:0];
        i_data  = pay;
        @(negedge i_clk);
        i_start = 1'b0;
        chk({name, "_acc_busy"}, 32'(o_busy), 32'd1);
        chk({name, "_acc_valid"}, 32'(tx_if.o_valid), 32'd1);
        chk({name, "_acc_sof"}, 32'(tx_if.o_data), 32'hAA);
        chk({name, "_done_clear"}, 32'(o_done), 32'd0);
        chk({name, "_len_err"}, 32'(o_len_err), (len > MAXP) ? 32'd1 : 32'd0);
        lerr = 0;
        cyc = 0; done_seen = 1'b0; stall = 1'b0; xfer_prev = 1'b0; held = 8'h00;
        while (!done_seen && cyc < 1000) begin
            if (stall) chk({name, "_hold"}, 32'(tx_if.o_data), 32'(held));
            if (o_done) begin
                done_seen = 1'b1;
                chk({name, "_done_after_xfer"}, 32'(xfer_prev), 32'd1);
                chk({name, "_end_busy"}, 32'(o_busy), 32'd0);
                chk({name, "_end_valid"}, 32'(tx_if.o_valid), 32'd0);
            end else begin
                if (cyc > 0) lerr += int'(o_len_err);
                chk({name, "_no_bubble"}, 32'(tx_if.o_valid), 32'd1);
                tx_if.i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rnd) i_start = 1'($urandom_range(0, 1));
                stall     = !tx_if.i_ready;
                xfer_prev = tx_if.i_ready;
                held      = tx_if.o_data;
                if (tx_if.i_ready) got_q.push_back(tx_if.o_data);
                @(negedge i_clk);
                cyc++;
            end
        end
        i_start = 1'b0;
        chk({name, "_finished"}, 32'(done_seen), 32'd1);
        chk({name, "_len_err_once"}, 32'(lerr), 32'd0);
        chk({name, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            chk($sformatf("%s_b%0d", name, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx,
                32'(exp_q[i]));
        end
        seq_m = seq_m + 8'd1;
    endtask

    // Directed sequence: reset, plain, stuffed, stalled, empty, oversize, reset mid-frame, back-to-back.
    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_id = 8'h00; i_len = '0; i_data = '0;
        tx_if.i_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(tx_if.o_valid), 32'd0);
        chk("rst_data", 32'(tx_if.o_data), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_len_err", 32'(o_len_err), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        run_frame("t1", 8'h01, 2, {8'h12, 8'h34, 112'd0}, 1'b0);
        chk("t1_transfers", 32'(got_q.size()), 32'(T1_N));
        chk("t1_id", 32'(got_q[3]), 32'h01);

        run_frame("t2", 8'h3F, 3, {24'hAAAAAA, 104'd0}, 1'b0);
        run_frame("t3", 8'h3F, 3, {24'hAAAAAA, 104'd0}, 1'b1);
        run_frame("t4", 8'hC5, 0, '0, 1'b0);
        run_frame("t5", 8'h21, MAXP + 1, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 1'b0);

        i_start = 1'b1; i_id = 8'h11; i_len = 5'd8; i_data = {8{16'hA55A}};
        @(negedge i_clk);
        i_start = 1'b0;
        tx_if.i_ready = 1'b1;
        repeat (6) @(negedge i_clk);
        chk("mid_in_frame", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("mid_rst_valid", 32'(tx_if.o_valid), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_data", 32'(tx_if.o_data), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        seq_m = 8'd0;

        run_frame("b2b0", 8'h02, 1, {8'h5A, 120'd0}, 1'b0);
`ifdef MIN_TX_TRANSPORT_EN
        chk("b2b0_hdr", 32'(got_q[3]), 32'h82);
        chk("b2b0_seq", 32'(got_q[4]), 32'h00);
`else
        chk("b2b0_hdr", 32'(got_q[3]), 32'h02);
        chk("b2b0_len", 32'(got_q[4]), 32'h01);
`endif
        run_frame("b2b1", 8'h02, 1, {8'h5A, 120'd0}, 1'b0);
`ifdef MIN_TX_TRANSPORT_EN
        chk("b2b1_seq", 32'(got_q[4]), 32'h01);
`else
        chk("b2b1_len", 32'(got_q[4]), 32'h01);
`endif
        run_frame("b2b2", 8'h02, 1, {8'h5A, 120'd0}, 1'b0);
`ifdef MIN_TX_TRANSPORT_EN
        chk("b2b2_seq", 32'(got_q[4]), 32'h02);
`else
        chk("b2b2_len", 32'(got_q[4]), 32'h01);
`endif
        @(negedge i_clk);
        chk("final_done_clear", 32'(o_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
